// File: rtl/conv_scan_counter_if.sv
// Coordinate handshake bundle between the layer controller / window-fetch datapath
// and the conv output-coordinate sequencer.
interface conv_scan_counter_if #(
    parameter int KW = 2,
    parameter int RW = 5,
    parameter int CW = 5,
    parameter int IW = 6
);
    logic          start;
    logic          abort;
    logic          out_ready;
    logic          out_valid;
    logic [KW-1:0] ch;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] in_row;
    logic [IW-1:0] in_col;
    logic          first;
    logic          last;
    logic          busy;
    logic          done;

    // The sequencer side.
    modport master (
        input  start, abort, out_ready,
        output out_valid, ch, row, col, in_row, in_col, first, last, busy, done
    );

    // The controller / consumer side.
    modport slave (
        output start, abort, out_ready,
        input  out_valid, ch, row, col, in_row, in_col, first, last, busy, done
    );
endinterface

// File: rtl/conv_scan_counter.sv
// Output-coordinate sequencer: walks (ch, row, col) with col innermost, presenting each
// position plus its strided input-window origin over a valid/ready handshake.
module conv_scan_counter #(
    parameter int ROWS     = 28,
    parameter int COLS     = 28,
    parameter int CHANNELS = 4,
    parameter int STRIDE   = 1,
    parameter int RW       = 5,
    parameter int CW       = 5,
    parameter int KW       = 2,
    parameter int IW       = 6
) (
    input  logic                clk,
    input  logic                rst,
    conv_scan_counter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] COL_MAX     = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX     = RW'(ROWS - 1);
    localparam logic [KW-1:0] CH_MAX      = KW'(CHANNELS - 1);
    localparam logic [IW-1:0] STEP        = IW'(STRIDE);
    localparam logic          SINGLE_BEAT = (ROWS == 1) && (COLS == 1) && (CHANNELS == 1);

    state_t        r_state;
    logic          r_valid, r_busy, r_done, r_first, r_last;
    logic [KW-1:0] r_ch;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [IW-1:0] r_in_row, r_in_col;

    logic          w_accept, w_col_wrap, w_row_wrap, w_last, w_nxt_last;
    logic [KW-1:0] w_nxt_ch;
    logic [RW-1:0] w_nxt_row;
    logic [CW-1:0] w_nxt_col;
    logic [IW-1:0] w_nxt_in_row, w_nxt_in_col;

    assign w_accept   = r_valid & bus.out_ready;
    assign w_col_wrap = (r_col == COL_MAX);
    assign w_row_wrap = (r_row == ROW_MAX);
    assign w_last     = w_col_wrap & w_row_wrap & (r_ch == CH_MAX);

    // Input origins advance by additions alongside the counters, so no multiplier.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_nxt_col    = r_col + 1'b1;
        w_nxt_in_col = r_in_col + STEP;
        w_nxt_row    = r_row;
        w_nxt_in_row = r_in_row;
        w_nxt_ch     = r_ch;
        if (w_col_wrap) begin
            w_nxt_col    = '0;
            w_nxt_in_col = '0;
            w_nxt_row    = r_row + 1'b1;
            w_nxt_in_row = r_in_row + STEP;
            if (w_row_wrap) begin
                w_nxt_row    = '0;
                w_nxt_in_row = '0;
                w_nxt_ch     = r_ch + 1'b1;
            end
        end
    end

    assign w_nxt_last = (w_nxt_col == COL_MAX) && (w_nxt_row == ROW_MAX) && (w_nxt_ch == CH_MAX);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_ch     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_in_row <= '0;
            r_in_col <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state  <= S_IDLE;
                r_valid  <= 1'b0;
                r_busy   <= 1'b0;
                r_first  <= 1'b0;
                r_last   <= 1'b0;
                r_ch     <= '0;
                r_row    <= '0;
                r_col    <= '0;
                r_in_row <= '0;
                r_in_col <= '0;
            end else begin
                case (r_state)
                    // Counters are already zero here: every exit from RUN clears them.
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_state <= S_RUN;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_first <= 1'b1;
                            r_last  <= SINGLE_BEAT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            if (w_last) begin
                                r_state  <= S_DONE;
                                r_valid  <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_first  <= 1'b0;
                                r_last   <= 1'b0;
                                r_ch     <= '0;
                                r_row    <= '0;
                                r_col    <= '0;
                                r_in_row <= '0;
                                r_in_col <= '0;
                            end else begin
                                r_first  <= 1'b0;
                                r_last   <= w_nxt_last;
                                r_ch     <= w_nxt_ch;
                                r_row    <= w_nxt_row;
                                r_col    <= w_nxt_col;
                                r_in_row <= w_nxt_in_row;
                                r_in_col <= w_nxt_in_col;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.first     = r_first;
    assign bus.last      = r_last;
    assign bus.ch        = r_ch;
    assign bus.row       = r_row;
    assign bus.col       = r_col;
    assign bus.in_row    = r_in_row;
    assign bus.in_col    = r_in_col;
endmodule

// File: tb/tb_conv_scan_counter.sv
// Directed bench for conv_scan_counter (2 ch x 2 rows x 3 cols, stride 2) with a
// scoreboard of expected beats pushed at start and popped on each accepted beat.
module tb_conv_scan_counter;
    typedef struct {
        int ch;
        int row;
        int col;
        int in_row;
        int in_col;
        bit first;
        bit last;
    } beat_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    beat_t exp_q[$];

    conv_scan_counter_if #(.KW(2), .RW(5), .CW(5), .IW(6)) bus ();

    conv_scan_counter #(
        .ROWS(2), .COLS(3), .CHANNELS(2), .STRIDE(2),
        .RW(5), .CW(5), .KW(2), .IW(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"},  32'(bus.out_valid), 0);
        check({tag, ".busy"},   32'(bus.busy),      0);
        check({tag, ".done"},   32'(bus.done),      0);
        check({tag, ".ch"},     32'(bus.ch),        0);
        check({tag, ".row"},    32'(bus.row),       0);
        check({tag, ".col"},    32'(bus.col),       0);
        check({tag, ".in_row"}, 32'(bus.in_row),    0);
        check({tag, ".in_col"}, 32'(bus.in_col),    0);
        check({tag, ".first"},  32'(bus.first),     0);
        check({tag, ".last"},   32'(bus.last),      0);
    endtask

    task automatic push_scan();
        beat_t e;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                for (int k = 0; k < 3; k++) begin
                    e.ch     = c;
                    e.row    = r;
                    e.col    = k;
                    e.in_row = r * 2;
                    e.in_col = k * 2;
                    e.first  = (c == 0) && (r == 0) && (k == 0);
                    e.last   = (c == 1) && (r == 1) && (k == 2);
                    exp_q.push_back(e);
                end
    endtask

    // Drives out_ready/start/abort each cycle and scores presented beats. Returns at the
    // sample point after the DONE cycle or after the abort edge.
    task automatic consume(input string tag, input int stall_beat, input int stall_len,
                           input int start_beat, input int abort_beat, input bit hold_start,
                           output int beats, output int first_cyc, output int last_cyc,
                           output int done_cyc, output int done_cnt);
        beat_t e;
        int    stalled;
        bit    fin;
        stalled = 0;
        fin = 1'b0;
        beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            bus.start     = hold_start;
            bus.abort     = 1'b0;
            bus.out_ready = 1'b1;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check({tag, ".done_valid"}, 32'(bus.out_valid), 0);
                check({tag, ".done_busy"},  32'(bus.busy),      0);
                fin = 1'b1;
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, ".extra_beat"}, 32'(bus.out_valid), 0);
                    fin = 1'b1;
                end else begin
                    e = exp_q[0];
                    check({tag, ".ch"},     32'(bus.ch),     32'(e.ch));
                    check({tag, ".row"},    32'(bus.row),    32'(e.row));
                    check({tag, ".col"},    32'(bus.col),    32'(e.col));
                    check({tag, ".in_row"}, 32'(bus.in_row), 32'(e.in_row));
                    check({tag, ".in_col"}, 32'(bus.in_col), 32'(e.in_col));
                    check({tag, ".first"},  32'(bus.first),  32'(e.first));
                    check({tag, ".last"},   32'(bus.last),   32'(e.last));
                    check({tag, ".busy"},   32'(bus.busy),   1);
                    if (beats == stall_beat && stalled < stall_len) begin
                        bus.out_ready = 1'b0;
                        stalled++;
                    end else begin
                        if (beats == start_beat) bus.start = 1'b1;
                        if (beats == abort_beat) begin
                            bus.abort = 1'b1;
                            fin = 1'b1;
                        end else begin
                            void'(exp_q.pop_front());
                            if (first_cyc < 0) first_cyc = cyc;
                            last_cyc = cyc;
                            beats++;
                        end
                    end
                end
            end
            tick();
        end
        check({tag, ".finished_in_budget"}, 32'(fin), 1);
        bus.abort = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int beats, first_cyc, last_cyc, done_cyc, done_cnt;

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset applied mid-cycle clears outputs immediately.
        #2 rst = 1'b1;
        #1 check_idle("reset");
        #20 rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Full scan at one beat per clock.
        push_scan();
        start_pulse();
        consume("full", -1, 0, -1, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("full.beats", beats, 12);
        check("full.first_cyc", first_cyc, 0);
        check("full.last_cyc", last_cyc, 11);
        check("full.done_cyc", done_cyc, 12);
        check("full.done_cnt", done_cnt, 1);
        check("full.queue_left", exp_q.size(), 0);
        check_idle("full.after");

        // Backpressure for 3 cycles at beat (0,0,1).
        push_scan();
        start_pulse();
        consume("stall", 1, 3, -1, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("stall.beats", beats, 12);
        check("stall.last_cyc", last_cyc, 14);
        check("stall.done_cnt", done_cnt, 1);
        check("stall.queue_left", exp_q.size(), 0);
        check_idle("stall.after");

        // Back-to-back: start held through DONE re-enters RUN at (0,0,0).
        push_scan();
        start_pulse();
        consume("b2b_a", -1, 0, -1, -1, 1'b1, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("b2b_a.beats", beats, 12);
        check("b2b_a.done_cnt", done_cnt, 1);
        push_scan();
        consume("b2b_b", -1, 0, -1, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("b2b_b.beats", beats, 12);
        check("b2b_b.first_cyc", first_cyc, 0);
        check("b2b_b.done_cnt", done_cnt, 1);
        check_idle("b2b.after");

        // Abort at beat (1,0,1): IDLE next cycle, no done pulse.
        push_scan();
        start_pulse();
        consume("abort", -1, 0, -1, 7, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("abort.beats", beats, 7);
        check("abort.done_cnt", done_cnt, 0);
        check_idle("abort.idle");
        tick();
        check_idle("abort.idle2");
        exp_q.delete();
        push_scan();
        start_pulse();
        consume("post_abort", -1, 0, -1, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("post_abort.beats", beats, 12);
        check("post_abort.done_cnt", done_cnt, 1);

        // Start pulsed during RUN at beat 5 is ignored.
        push_scan();
        start_pulse();
        consume("ign_start", -1, 0, 4, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("ign_start.beats", beats, 12);
        check("ign_start.last_cyc", last_cyc, 11);
        check("ign_start.done_cnt", done_cnt, 1);
        check_idle("ign_start.after");

        // Asynchronous reset in the middle of a scan.
        bus.out_ready = 1'b1;
        start_pulse();
        tick();
        tick();
        check("mid.valid_before_rst", 32'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1 check_idle("mid_rst");
        #2 rst = 1'b0;
        tick();
        check_idle("mid_rst.after");
        exp_q.delete();
        push_scan();
        start_pulse();
        consume("post_rst", -1, 0, -1, -1, 1'b0, beats, first_cyc, last_cyc, done_cyc, done_cnt);
        check("post_rst.beats", beats, 12);
        check("post_rst.done_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
